// File: rtl/demux_1to4_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants for the 1-to-4 scheduled demux: state
//                encodings, mode encodings and sink count.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int NUM_SINKS = 4;

    localparam logic [0:0] ST_EMPTY  = 1'b0;
    localparam logic [0:0] ST_FULL   = 1'b1;

    localparam logic       MODE_ADDR = 1'b0;
    localparam logic       MODE_RR   = 1'b1;

    // One-hot decode of a sink index.
    function automatic logic [NUM_SINKS-1:0] sink_onehot(input logic [1:0] idx);
        logic [NUM_SINKS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_1to4_sched_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational cyclic first-set search over a 4-bit enable
//                mask, starting at a 2-bit pointer (0->1->2->3->0).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import demux_pkg::*;
(
    input  logic [1:0]           i_ptr,
    input  logic [NUM_SINKS-1:0] i_en,
    output logic [1:0]           o_dest,
    output logic                 o_none
);

    // Scan from the farthest offset down so the nearest enabled sink wins.
    always_comb begin
        logic [1:0] w_idx;
        o_dest = i_ptr;
        o_none = (i_en == '0);
        for (int k = NUM_SINKS - 1; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_en[w_idx]) begin
                o_dest = w_idx;
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/demux_1to4_sched.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1to4_sched
//  Description : Registered 1-to-4 demux with valid/ready handshakes, a
//                one-entry output buffer, per-word (ADDR) or round-robin (RR)
//                sink selection and a saturating dropped-word counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4_sched
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DROP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [NUM_SINKS-1:0] en,
    input  logic                 in_valid,
    input  logic [1:0]           in_dest,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NUM_SINKS-1:0] out_valid,
    output logic [DATA_W-1:0]    out_data,
    input  logic [NUM_SINKS-1:0] out_ready,
    output logic [DROP_W-1:0]    drop_cnt,
    output logic                 busy
);

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_dest;
    logic [1:0]        r_rr_ptr;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [1:0]        w_pick_dest;
    logic              w_pick_none;
    logic [1:0]        w_dest;
    logic              w_drop;
    logic              w_drain;
    logic              w_accept;
    logic              w_load;

    rr_pick4 u_rr_pick4 (
        .i_ptr  (r_rr_ptr),
        .i_en   (en),
        .o_dest (w_pick_dest),
        .o_none (w_pick_none)
    );

    // Handshake terms and destination/drop decision for the offered word.
    always_comb begin
        w_drain  = (r_state == ST_FULL) && out_ready[r_dest];
        w_dest   = (mode == MODE_RR) ? w_pick_dest : in_dest;
        w_drop   = (mode == MODE_RR) ? w_pick_none : ~en[in_dest];
        w_accept = in_valid & in_ready;
        w_load   = w_accept & ~w_drop;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a kept word fills the buffer; a drain alone empties it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_next_state = ST_FULL;
            ST_FULL: begin
                if (w_load) begin
                    w_next_state = ST_FULL;
                end else if (w_drain) begin
                    w_next_state = ST_EMPTY;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    // FSM outputs: FULL accepts only when the held word leaves this cycle.
    always_comb begin
        in_ready  = (r_state == ST_EMPTY) ? 1'b1 : w_drain;
        busy      = (r_state == ST_FULL);
        out_valid = (r_state == ST_FULL) ? sink_onehot(r_dest) : '0;
        out_data  = r_data;
        drop_cnt  = r_drop_cnt;
    end

    // Data/dest register; only loaded by a kept word, so held words stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_dest <= '0;
        end else if (w_load) begin
            r_data <= in_data;
            r_dest <= w_dest;
        end
    end

    // Round-robin pointer advances past the sink just chosen in RR mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load && (mode == MODE_RR)) begin
            r_rr_ptr <= w_dest + 2'd1;
        end
    end

    // Saturating count of accepted-but-dropped words.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

endmodule : demux_1to4_sched
`default_nettype wire

// File: tb/tb_demux_1to4_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1to4_sched
//  Description : Self-checking bench for demux_1to4_sched with directed
//                scenarios and randomized traffic against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [3:0] en;
    logic       in_valid;
    logic [1:0] in_dest;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic [7:0] drop_cnt;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: buffer contents, pointer and drop count.
    bit         m_full;
    logic [7:0] m_data;
    int         m_dest;
    int         m_ptr;
    int         m_drops;

    always #5 clk = ~clk;

    demux_1to4_sched #(.DATA_W(8), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .en        (en),
        .in_valid  (in_valid),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_full  = 0;
        m_data  = 8'h00;
        m_dest  = 0;
        m_ptr   = 0;
        m_drops = 0;
    endtask

    // One clock: drive, compare against model, clock, advance model.
    task automatic step(input bit r, input bit md, input logic [3:0] e, input bit v,
                        input logic [1:0] d, input logic [7:0] dat, input logic [3:0] rd);
        bit   exp_rdy;
        bit   acc;
        bit   drain;
        bit   keep;
        int   pick;
        logic [3:0] exp_ov;
        @(negedge clk);
        rst = r; mode = md; en = e; in_valid = v; in_dest = d; in_data = dat; out_ready = rd;
        #1;
        exp_rdy = !m_full || rd[m_dest];
        exp_ov  = m_full ? (4'b0001 << m_dest) : 4'b0000;
        chk("in_ready",  {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
        if (m_full) chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("busy",      {31'd0, busy}, {31'd0, m_full});
        chk("drop_cnt",  {24'd0, drop_cnt}, m_drops);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            acc   = v && exp_rdy;
            drain = m_full && rd[m_dest];
            keep  = 0;
            pick  = 0;
            if (acc) begin
                if (md == 1'b0) begin
                    pick = d;
                    keep = e[d];
                end else begin
                    for (int k = 3; k >= 0; k--) begin
                        if (e[(m_ptr + k) % 4]) begin
                            pick = (m_ptr + k) % 4;
                            keep = 1;
                        end
                    end
                end
            end
            if (keep) begin
                m_full = 1;
                m_data = dat;
                m_dest = pick;
                if (md) m_ptr = (pick + 1) % 4;
            end else begin
                if (acc && m_drops < 255) m_drops++;
                if (drain) m_full = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [3:0] exp1 [4];
        logic [3:0] exp2 [5];
        logic [3:0] r_en;
        exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp2 = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};

        rst = 1; mode = 0; en = 4'hF; in_valid = 0; in_dest = 0; in_data = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_out_valid", {28'd0, out_valid}, 0);
        chk("rst_out_data",  {24'd0, out_data}, 0);
        chk("rst_busy",      {31'd0, busy}, 0);
        chk("rst_drop_cnt",  {24'd0, drop_cnt}, 0);

        // 1: ADDR, all enabled, one word per sink.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 4'hF, 1, 2'(i), 8'hA0 + 8'(i), 4'hF);
            chk("t1_onehot", {28'd0, out_valid}, {28'd0, exp1[i]});
            chk("t1_data",   {24'd0, out_data}, 32'hA0 + i);
        end

        // 2: RR over en=1011, pointer wraps 3->0.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 4'b1011, 1, 2'd0, 8'hB0 + 8'(i), 4'hF);
            chk("t2_rr_sink", {28'd0, out_valid}, {28'd0, exp2[i]});
        end

        // 3: backpressure on sink 2, then drain+accept in one cycle.
        step(0, 0, 4'hF, 1, 2'd2, 8'h44, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'hF, 1, 2'd2, 8'h55, 4'h0);
            chk("t3_hold_valid", {28'd0, out_valid}, 32'h4);
            chk("t3_hold_data",  {24'd0, out_data}, 32'h44);
            chk("t3_in_ready",   {31'd0, in_ready}, 0);
        end
        step(0, 0, 4'hF, 1, 2'd2, 8'h66, 4'b0100);
        chk("t3_b2b_valid", {28'd0, out_valid}, 32'h4);
        chk("t3_b2b_data",  {24'd0, out_data}, 32'h66);
        step(0, 0, 4'hF, 0, 2'd0, 8'h00, 4'hF);

        // 4: drops to a disabled sink, then saturation.
        step(0, 0, 4'b1101, 1, 2'd1, 8'h77, 4'hF);
        chk("t4_drop1",   {24'd0, drop_cnt}, 1);
        chk("t4_no_valid", {28'd0, out_valid}, 0);
        for (int i = 0; i < 300; i++) step(0, 0, 4'b1101, 1, 2'd1, 8'(i), 4'hF);
        chk("t4_saturate", {24'd0, drop_cnt}, 32'hFF);

        // 5: reset while a word waits for sink 3.
        step(0, 0, 4'hF, 1, 2'd3, 8'h99, 4'h0);
        step(1, 0, 4'hF, 0, 2'd0, 8'h00, 4'h0);
        chk("t5_valid", {28'd0, out_valid}, 0);
        chk("t5_busy",  {31'd0, busy}, 0);
        chk("t5_drops", {24'd0, drop_cnt}, 0);
        step(0, 1, 4'hF, 1, 2'd2, 8'hC0, 4'h0);
        chk("t5_rr_ptr0", {28'd0, out_valid}, 32'h1);
        step(0, 0, 4'hF, 0, 2'd0, 8'h00, 4'hF);

        // 6: ready on every sink except the addressed one.
        step(0, 0, 4'hF, 1, 2'd1, 8'hD1, 4'h0);
        step(0, 0, 4'hF, 0, 2'd0, 8'h00, 4'b1101);
        chk("t6_held",  {28'd0, out_valid}, 32'h2);
        chk("t6_data",  {24'd0, out_data}, 32'hD1);
        chk("t6_busy",  {31'd0, busy}, 1);
        step(0, 0, 4'hF, 0, 2'd0, 8'h00, 4'hF);

        // Randomized traffic with occasional reset and enable changes.
        r_en = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r_en = 4'($urandom);
            step($urandom_range(0, 199) == 0, 1'($urandom), r_en, 1'($urandom_range(0, 3) != 0),
                 2'($urandom), 8'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux_1to4_sched
`default_nettype wire
